seg_shift_display: RTL
======================

Name: seg_shift_display

Overview:
- Parametrised successor to the 8-digit seven-segment editor.
- Holds a DIGITS-deep buffer of 7-bit segment codes. Right/left button edges shift the buffer, inserting a new code or a blank.
- A timed fill mode copies digit 0 into successive positions, exits by itself, and can be aborted.
- Drives the time-multiplexed anode/cathode outputs of the board display. Sits between the code decoder (code_in) and the board pins.

Parameters:
- DIGITS, 8, number of display positions, 2..16.
- SCAN_DIV, 10000, clk cycles per anode step.
- FILL_DIV, 100000000, clk cycles per fill step.
- ROTATE, 0, shift-left fill source: 0 = blank enters digit DIGITS-1; 1 = old digit 0 wraps into DIGITS-1.
- BLANK, 7'h7F, segment pattern for an unlit digit (active-low segments).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- btn_r  in  1  raw right button; rising edge shifts right.
- btn_l  in  1  raw left button; rising edge shifts left.
- fill_start  in  1  raw level; rising edge starts fill mode.
- code_in  in  7  segment code inserted at digit 0 on shift right.
- HEX  out  7  cathode pattern of the currently scanned digit.
- AN  out  DIGITS  one-hot-low anode select.
- busy  out  1  high while in FILL.
- fill_idx  out  clog2(DIGITS)  next position the fill will write; 0 in IDLE.

Behaviour:
- Reset, asynchronous, while reset=0:
  - all digits = BLANK; AN = all ones except bit 0 low; HEX = BLANK.
  - busy=0, fill_idx=0, state IDLE; scan and fill counters 0; synchronisers 0.
- Input conditioning:
  - each of btn_r, btn_l, fill_start passes through a 2-flop synchroniser plus one history flop.
  - pulse = sync_q & ~hist_q, exactly one cycle wide per rising edge.
  - an input going high before clk edge N acts on the buffer/state at edge N+3.
  - no debounce here; bounce yields multiple pulses.
- Scan:
  - scan counter runs 0..SCAN_DIV-1 and wraps to 0.
  - tick is asserted when counter == SCAN_DIV-1.
  - on tick, the scan index advances modulo DIGITS, and AN rotates its low bit one position left, wrapping bit DIGITS-1 back to bit 0.
  - HEX = digit[scan index], combinational from registered index; never X, index always < DIGITS.
- IDLE:
  - r pulse: digit[k] <= digit[k-1] for k>=1; digit[0] <= code_in; digit[DIGITS-1] is discarded.
  - l pulse: digit[k] <= digit[k+1] for k < DIGITS-1; digit[DIGITS-1] <= BLANK (ROTATE=0) or old digit[0] (ROTATE=1).
  - r and l pulses in the same cycle: right wins, left is dropped.
  - fill_start pulse with no r/l pulse: go to FILL, fill_idx <= 1, fill counter <= 0, busy <= 1.
  - fill_start together with r or l: the shift happens, fill_start is dropped.
- FILL:
  - fill counter increments each cycle.
  - at FILL_DIV-1 it clears, digit[fill_idx] <= digit[0], fill_idx increments.
  - the step writing DIGITS-1 also returns to IDLE: busy <= 0, fill_idx <= 0.
  - any r or l pulse in FILL aborts to IDLE in that cycle; the press is consumed (no shift), and the buffer keeps the digits filled so far.
  - abort and a fill step in the same cycle: abort wins, no write.
  - fill_start pulses in FILL are ignored.
- Widths:
  - scan counter width clog2(SCAN_DIV); fill counter width clog2(FILL_DIV).
  - no truncation of FILL_DIV = 1e8, which needs 27 bits.
- Reset mid-fill or mid-scan returns immediately to the reset values; no partial state survives.

Decomposition:
- Shared package seg_pkg: BLANK default, state encoding (IDLE, FILL), a clog2-safe width function.
- Sub-module edge_sync, instantiated 3x: 2-flop synchroniser + rising-edge pulse, same clk and reset.
- Buffer, FSM and scan stay in seg_shift_display.

Test Plan (DIGITS=4, SCAN_DIV=4, FILL_DIV=8, ROTATE=0 unless noted):
- Reset release, then no stimulus -> AN sequence 1110, 1101, 1011, 0111, 1110, changing every 4 cycles; HEX=7F throughout; busy=0.
- code_in=40, btn_r pulsed; then code_in=79, btn_r pulsed -> digit0=79, digit1=40; HEX=79 while AN=1110 and 40 while AN=1101; change lands 3 edges after the input rises.
- Buffer {0:40, 1:79, 2:24, 3:30}, btn_l -> {79, 24, 30, 7F}. Same start with ROTATE=1 -> {79, 24, 30, 40}.
- Buffer digit0=12, others 7F; raise fill_start -> busy=1; digits 1, 2, 3 become 12 at 8-cycle intervals; busy=0 and fill_idx=0 in the same cycle digit 3 is written.
- Fill started with digit0=12; btn_r pulse after the first step -> busy=0, digit1=12, digit2=digit3=7F, digit0 unchanged (no shift).
- btn_r and btn_l raised on the same edge -> only the right shift occurs; reset asserted mid-fill -> all outputs return to reset values asynchronously, before the next clk edge.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the shifting seven-segment display.
package seg_pkg;

  localparam logic [6:0] BLANK_DEFAULT = 7'h7F;

  typedef enum logic {
    StIdle,
    StFill
  } state_e;

  // Never returns 0, so a divider of 1 still gets a one-bit counter.
  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_shift_display_if.sv
// Button/code inputs and display outputs of seg_shift_display.
interface seg_shift_display_if #(
  parameter int unsigned DIGITS = 8
) ();

  localparam int unsigned IdxW = seg_pkg::safe_clog2(DIGITS);

  logic              btn_r;
  logic              btn_l;
  logic              fill_start;
  logic [6:0]        code_in;
  logic [6:0]        HEX;
  logic [DIGITS-1:0] AN;
  logic              busy;
  logic [IdxW-1:0]   fill_idx;

  modport master (
    output btn_r, btn_l, fill_start, code_in,
    input  HEX, AN, busy, fill_idx
  );

  modport slave (
    input  btn_r, btn_l, fill_start, code_in,
    output HEX, AN, busy, fill_idx
  );

endinterface

// File: rtl/edge_sync.sv
// Two-flop synchroniser with a registered one-cycle rising-edge pulse.
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_pulse
);

  logic r_meta;
  logic r_sync;
  logic r_hist;
  logic r_pulse;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_hist  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_meta  <= i_d;
      r_sync  <= r_meta;
      r_hist  <= r_sync;
      r_pulse <= r_sync & ~r_hist;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/seg_shift_display.sv
// Shifting segment-code buffer with timed fill mode and multiplexed anode scan.
module seg_shift_display
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned SCAN_DIV = 10000,
  parameter int unsigned FILL_DIV = 100000000,
  parameter int unsigned ROTATE   = 0,
  parameter logic [6:0]  BLANK    = BLANK_DEFAULT
) (
  input logic             clk,
  input logic             reset,
  seg_shift_display_if.slave bus
);

  localparam int unsigned IdxW  = safe_clog2(DIGITS);
  localparam int unsigned ScanW = safe_clog2(SCAN_DIV);
  localparam int unsigned FillW = safe_clog2(FILL_DIV);

  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(DIGITS - 1);
  localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_DIV - 1);
  localparam logic [FillW-1:0] FillLast = FillW'(FILL_DIV - 1);

  logic w_pulse_r;
  logic w_pulse_l;
  logic w_pulse_f;

  edge_sync u_sync_r (
    .clk     (clk),
    .reset   (reset),
    .i_d     (bus.btn_r),
    .o_pulse (w_pulse_r)
  );

  edge_sync u_sync_l (
    .clk     (clk),
    .reset   (reset),
    .i_d     (bus.btn_l),
    .o_pulse (w_pulse_l)
  );

  edge_sync u_sync_f (
    .clk     (clk),
    .reset   (reset),
    .i_d     (bus.fill_start),
    .o_pulse (w_pulse_f)
  );

  // Anode scan
  logic [ScanW-1:0]  r_scan_cnt;
  logic [IdxW-1:0]   r_scan_idx;
  logic [DIGITS-1:0] r_an;
  logic              w_tick;

  assign w_tick = (r_scan_cnt == ScanLast);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_scan_cnt <= '0;
      r_scan_idx <= '0;
      r_an       <= ~DIGITS'(1);
    end else if (w_tick) begin
      r_scan_cnt <= '0;
      r_scan_idx <= (r_scan_idx == IdxLast) ? '0 : r_scan_idx + 1'b1;
      r_an       <= {r_an[DIGITS-2:0], r_an[DIGITS-1]};
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  // Buffer and fill FSM
  state_e          r_state;
  state_e          w_state_d;
  logic [IdxW-1:0] r_fill_idx;
  logic [IdxW-1:0] w_fill_idx_d;
  logic [FillW-1:0] r_fill_cnt;
  logic [FillW-1:0] w_fill_cnt_d;
  logic [6:0]      r_digit   [DIGITS];
  logic [6:0]      w_digit_d [DIGITS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= StIdle;
      r_fill_idx <= '0;
      r_fill_cnt <= '0;
      for (int k = 0; k < DIGITS; k++) begin
        r_digit[k] <= BLANK;
      end
    end else begin
      r_state    <= w_state_d;
      r_fill_idx <= w_fill_idx_d;
      r_fill_cnt <= w_fill_cnt_d;
      r_digit    <= w_digit_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_fill_idx_d = r_fill_idx;
    w_fill_cnt_d = r_fill_cnt;
    w_digit_d    = r_digit;
    unique case (r_state)
      StIdle: begin
        w_fill_cnt_d = '0;
        // Right beats left, and any shift swallows a simultaneous fill_start.
        if (w_pulse_r) begin
          w_digit_d[0] = bus.code_in;
          for (int k = 1; k < DIGITS; k++) begin
            w_digit_d[k] = r_digit[k-1];
          end
        end else if (w_pulse_l) begin
          for (int k = 0; k < DIGITS - 1; k++) begin
            w_digit_d[k] = r_digit[k+1];
          end
          w_digit_d[DIGITS-1] = (ROTATE != 0) ? r_digit[0] : BLANK;
        end else if (w_pulse_f) begin
          w_state_d    = StFill;
          w_fill_idx_d = IdxW'(1);
        end
      end
      StFill: begin
        if (w_pulse_r || w_pulse_l) begin
          // Abort consumes the press; digits filled so far stay.
          w_state_d    = StIdle;
          w_fill_idx_d = '0;
          w_fill_cnt_d = '0;
        end else if (r_fill_cnt == FillLast) begin
          w_fill_cnt_d          = '0;
          w_digit_d[r_fill_idx] = r_digit[0];
          if (r_fill_idx == IdxLast) begin
            w_state_d    = StIdle;
            w_fill_idx_d = '0;
          end else begin
            w_fill_idx_d = r_fill_idx + 1'b1;
          end
        end else begin
          w_fill_cnt_d = r_fill_cnt + 1'b1;
        end
      end
      default: begin
        w_state_d    = StIdle;
        w_fill_idx_d = '0;
        w_fill_cnt_d = '0;
      end
    endcase
  end

  assign bus.HEX      = r_digit[r_scan_idx];
  assign bus.AN       = r_an;
  assign bus.busy     = (r_state == StFill);
  assign bus.fill_idx = r_fill_idx;

endmodule
